// File: rtl/div_result_buffer.sv
// div_result_buffer: captures every unstallable divider result into a small
// FIFO and re-presents it on a ready/valid interface. Tags divide-by-zero
// results, raises a sticky overflow flag on drops and provides an issue
// permit for the upstream divider handshake.
// Optional feature: define DIV_RES_DROP_CNT_EN to build the saturating
// drop counter; otherwise o_drop_count is tied to zero.
module div_result_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_payload_1,
  input  logic [WIDTH-1:0] i_payload_2,
  output logic             o_issue_ok,
  input  logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_payload_quotient,
  output logic [WIDTH-1:0] o_payload_remainder,
  output logic             o_payload_divzero,
  output logic             o_overflow,
  output logic [7:0]       o_drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [CW-1:0] ISSUE_MAX = CW'(DEPTH - 2);

  // The divider encodes divide-by-zero as an all-ones quotient/remainder pair
  function automatic logic is_divzero(input logic [WIDTH-1:0] q,
                                      input logic [WIDTH-1:0] r);
    return (&q) && (&r);
  endfunction

  logic [WIDTH-1:0] quot_mem [DEPTH];
  logic [WIDTH-1:0] rem_mem  [DEPTH];
  logic             dz_mem   [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;
  logic             drop;

  // A full FIFO still accepts a result when the head leaves in the same cycle
  always_comb begin
    pop  = o_valid && o_ready;
    push = i_valid && ((count != FULL) || pop);
    drop = i_valid && (count == FULL) && !pop;
  end

  assign o_valid             = (count != '0);
  assign o_issue_ok          = (count <= ISSUE_MAX);
  assign o_payload_quotient  = quot_mem[rd_ptr];
  assign o_payload_remainder = rem_mem[rd_ptr];
  assign o_payload_divzero   = dz_mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage, cleared on reset so the head reads as zero afterwards
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        quot_mem[i] <= '0;
        rem_mem[i]  <= '0;
        dz_mem[i]   <= 1'b0;
      end
    end else if (push) begin
      quot_mem[wr_ptr] <= i_payload_1;
      rem_mem[wr_ptr]  <= i_payload_2;
      dz_mem[wr_ptr]   <= is_divzero(i_payload_1, i_payload_2);
    end
  end

  // Sticky overflow: any dropped result is remembered until reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    o_overflow <= 1'b0;
    else if (drop) o_overflow <= 1'b1;
  end

`ifdef DIV_RES_DROP_CNT_EN
  // Counter holds at its maximum rather than wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Saturating count of dropped results
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    o_drop_count <= 8'd0;
    else if (drop) o_drop_count <= sat_inc8(o_drop_count);
  end
`else
  assign o_drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_div_result_buffer.sv
// Testbench for div_result_buffer: directed scenarios followed by random
// traffic, checked by a queue-based scoreboard and a negedge monitor.
module tb_div_result_buffer;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;
  } entry_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             i_valid = 1'b0;
  logic [WIDTH-1:0] i_payload_1 = '0;
  logic [WIDTH-1:0] i_payload_2 = '0;
  logic             o_issue_ok;
  logic             o_ready = 1'b0;
  logic             o_valid;
  logic [WIDTH-1:0] o_payload_quotient;
  logic [WIDTH-1:0] o_payload_remainder;
  logic             o_payload_divzero;
  logic             o_overflow;
  logic [7:0]       o_drop_count;

  entry_t exp_q[$];
  logic   exp_ovf = 1'b0;
  int     exp_drops = 0;
  int     tests = 0;
  int     fails = 0;

  div_result_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk                 (clk),
    .reset               (reset),
    .i_valid             (i_valid),
    .i_payload_1         (i_payload_1),
    .i_payload_2         (i_payload_2),
    .o_issue_ok          (o_issue_ok),
    .o_ready             (o_ready),
    .o_valid             (o_valid),
    .o_payload_quotient  (o_payload_quotient),
    .o_payload_remainder (o_payload_remainder),
    .o_payload_divzero   (o_payload_divzero),
    .o_overflow          (o_overflow),
    .o_drop_count        (o_drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int exp_drop_count();
`ifdef DIV_RES_DROP_CNT_EN
    return (exp_drops > 255) ? 255 : exp_drops;
`else
    return 0;
`endif
  endfunction

  // Monitor: compares every visible output with the model, then retires the
  // head when the consumer takes it at the coming edge
  always @(negedge clk) begin
    if (reset) begin
      check("o_valid", o_valid, exp_q.size() != 0);
      check("o_issue_ok", o_issue_ok, (DEPTH - exp_q.size()) >= 2);
      check("o_overflow", o_overflow, exp_ovf);
      check("o_drop_count", o_drop_count, exp_drop_count());
      if (o_valid && exp_q.size() != 0) begin
        check("head quotient", o_payload_quotient, exp_q[0].q);
        check("head remainder", o_payload_remainder, exp_q[0].r);
        check("head divzero", o_payload_divzero, exp_q[0].dz);
        if (o_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Model commit at the clock edge: the queue already reflects any pop
  task automatic commit(input logic v, input logic [WIDTH-1:0] q,
                        input logic [WIDTH-1:0] r);
    entry_t e;
    if (reset && v) begin
      if (exp_q.size() < DEPTH) begin
        e.q  = q;
        e.r  = r;
        e.dz = (q == {WIDTH{1'b1}}) && (r == {WIDTH{1'b1}});
        exp_q.push_back(e);
      end else begin
        exp_ovf = 1'b1;
        exp_drops++;
      end
    end
  endtask

  // One clock of stimulus, driven just after the previous rising edge
  task automatic cycle(input logic v, input logic [WIDTH-1:0] q,
                       input logic [WIDTH-1:0] r, input logic rdy);
    i_valid     = v;
    i_payload_1 = q;
    i_payload_2 = r;
    o_ready     = rdy;
    @(posedge clk);
    commit(v, q, r);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    logic [WIDTH-1:0] ones;
    ones = {WIDTH{1'b1}};

    // Reset state, including cleared storage behind the head
    #12;
    check("reset o_valid", o_valid, 0);
    check("reset o_issue_ok", o_issue_ok, 1);
    check("reset o_overflow", o_overflow, 0);
    check("reset o_drop_count", o_drop_count, 0);
    check("reset quotient", o_payload_quotient, 0);
    check("reset remainder", o_payload_remainder, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Single result held, then popped
    cycle(1'b1, 32'd3, 32'd2, 1'b0);
    cycle(1'b0, '0, '0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0);

    // Divide-by-zero tagging
    cycle(1'b1, ones, ones, 1'b0);
    cycle(1'b1, ones, 32'd0, 1'b0);
    drain();

    // Fill to full, then one dropped result, then ordered drain
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h100 + i, 32'h10 + i, 1'b0);
    cycle(1'b1, 32'hDEAD, 32'hBEEF, 1'b0);
    cycle(1'b0, '0, '0, 1'b0);
    drain();

    // Full with simultaneous push and pop across pointer wrap
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h200 + i, 32'h20 + i, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'h300 + i, 32'h30 + i, 1'b1);
    drain();

    // Asynchronous reset between edges with three entries queued
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h400 + i, 32'h40 + i, 1'b0);
    i_valid = 1'b0;
    #2;
    reset = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_drops = 0;
    #1;
    check("async o_valid", o_valid, 0);
    check("async o_issue_ok", o_issue_ok, 1);
    check("async o_overflow", o_overflow, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycle(1'b1, 32'h55, 32'h5, 1'b0);
    cycle(1'b0, '0, '0, 1'b0);
    drain();

    // Random traffic with varying consumer pressure
    for (int i = 0; i < 3000; i++) begin
      logic             v;
      logic             rdy;
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] r;
      v   = ($urandom_range(0, 99) < 60);
      rdy = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 40 : 85));
      q   = ($urandom_range(0, 9) == 0) ? ones : $urandom;
      r   = ($urandom_range(0, 4) == 0) ? ones : $urandom;
      cycle(v, q, r, rdy);
    end
    drain();
    check("final empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_result_buffer.md
# div_result_buffer

Downstream stage of the unsigned divider. The divider emits a one-cycle quotient/remainder pulse and cannot be stalled. This block captures every result into a small FIFO and re-presents it to the consumer on a ready/valid interface. It also flags divide-by-zero results and supplies an issue-permit signal that upstream logic ANDs into the divider's input handshake, so no result is lost in normal operation.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- WIDTH, 32, quotient and remainder width (matches divider)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset: assertion clears state immediately, release is synchronous to clk
- i_valid  in  1  divider result pulse (divider o_valid)
- i_payload_1  in  WIDTH  quotient
- i_payload_2  in  WIDTH  remainder
- o_issue_ok  out  1  high when at least 2 entries are free (one for an in-flight result, one for a new issue)
- o_ready  in  1  consumer accepts head entry
- o_valid  out  1  head entry valid
- o_payload_quotient  out  WIDTH  head quotient
- o_payload_remainder  out  WIDTH  head remainder
- o_payload_divzero  out  1  head entry was a divide-by-zero result
- o_overflow  out  1  sticky: a result arrived while the FIFO was full and was dropped
- o_drop_count  out  8  saturating drop counter (see Configuration)

## Operation
- Storage: DEPTH × (2·WIDTH+1) entries, a write pointer, a read pointer, and a count register of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Push: occurs when i_valid=1 and (count<DEPTH, or a pop occurs in the same cycle). Stores quotient, remainder and divzero.
- divzero = (i_payload_1 == all 1s) && (i_payload_2 == all 1s). This pair is unambiguous: a valid remainder never equals all 1s.
- Pop: occurs when o_valid && o_ready.
- Drop: occurs when i_valid=1, count==DEPTH and no pop occurs. The entry is discarded, o_overflow is set to 1 and stays set until reset.
- Simultaneous push and pop: count is unchanged and both pointers advance. When full, the push is accepted rather than dropped.
- Pop when empty: no effect, because o_valid=0.
- o_valid = (count != 0).
- o_payload_* show the head entry combinationally from the storage array. Their values are don't-care while o_valid=0.
- o_issue_ok = (DEPTH − count ≥ 2). It is registered-count based and carries no dependency on i_valid.
- No state machine beyond the FIFO pointers and count.

## Timing
- Reset values: count=0, pointers=0, o_valid=0, o_issue_ok=1, o_overflow=0, o_drop_count=0. Payload outputs are 0 after reset because storage is cleared on reset.
- Latency: a result pushed in cycle N into an empty FIFO gives o_valid=1 in cycle N+1 with that data.
- Throughput: one push and one pop per cycle sustained.
- o_valid and payload stay stable until popped. The head never changes while o_valid=1 and o_ready=0.
- o_issue_ok updates the cycle after any count change.
- Reset asserted mid-operation: all entries are discarded immediately and the outputs return to their reset values asynchronously.

## Configuration
- Macro DIV_RES_DROP_CNT_EN.
- Defined: o_drop_count increments on every drop and saturates at 255. It is cleared only by reset.
- Undefined: the counter logic is not built and o_drop_count is tied to 0. o_overflow behaves identically in both builds.

## Test plan
- Single result: after reset, pulse i_valid with q=3, r=2 while o_ready=0 → next cycle o_valid=1, quotient=3, remainder=2, divzero=0. Then o_ready=1 for one cycle → o_valid=0.
- Divide-by-zero tag: push q=0xFFFFFFFF, r=0xFFFFFFFF → divzero=1. Push q=0xFFFFFFFF, r=0 → divzero=0.
- Fill and credit with DEPTH=4 and o_ready=0: o_issue_ok is 1 at counts 0–2, drops to 0 the cycle after count reaches 3, and o_overflow stays 0 through 4 pushes.
- Overflow: a 5th push while full with no pop → entry dropped, o_overflow=1. Drain returns the first 4 entries in order. With the macro defined, o_drop_count=1.
- Full plus simultaneous push and pop: with count=4, o_ready=1 and i_valid=1 in the same cycle → no drop, count stays 4, and the output order is preserved across pointer wrap.
- Async reset mid-stream: assert reset with count=3 between clock edges → o_valid=0 and o_issue_ok=1 immediately. After release, the first new push appears alone.
